// File: rtl/ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ram_bist_ctrl
//  Purpose  : Built-in self-test sequencer for a single-port RAM. Writes a
//             seed+address pattern to every location, reads it back in order,
//             and reports pass/fail, a mismatch count and the first bad address.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_bist_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   MAX_ERR   = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   seed_q;
  // Compare pipeline: describes the read issued in the previous cycle, so it
  // lines up with ram_dout coming back from the RAM's registered read port.
  logic                    cmp_valid;
  logic [ADDR_WIDTH-1:0]   cmp_addr;
  logic [DATA_WIDTH-1:0]   cmp_exp;
  logic                    mismatch;
  logic [ADDR_WIDTH:0]     err_next;

  // Evaluate the pending compare and the saturating error count it produces.
  always_comb begin
    mismatch = cmp_valid && (ram_dout != cmp_exp);
    err_next = err_cnt;
    if (mismatch && (err_cnt != MAX_ERR)) begin
      err_next = err_cnt + 1'b1;
    end
  end

  // Sequencer: drives the RAM port, runs the compare pipeline, keeps results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      seed_q         <= '0;
      cmp_valid      <= 1'b0;
      cmp_addr       <= '0;
      cmp_exp        <= '0;
      ram_en         <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_din        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      done      <= 1'b0;
      // A read on the bus this cycle returns data next cycle.
      cmp_valid <= ram_en & ~ram_we;
      cmp_addr  <= ram_addr;
      cmp_exp   <= seed_q + DATA_WIDTH'(ram_addr);
      err_cnt   <= err_next;
      if (mismatch && (err_cnt == '0)) begin
        first_err_addr <= cmp_addr;
      end

      case (state)
        S_IDLE: begin
          ram_en   <= 1'b0;
          ram_we   <= 1'b0;
          ram_addr <= '0;
          ram_din  <= '0;
          if (start) begin
            seed_q         <= seed;
            err_cnt        <= '0;
            pass           <= 1'b0;
            first_err_addr <= '0;
            busy           <= 1'b1;
            ram_en         <= 1'b1;
            ram_we         <= 1'b1;
            ram_din        <= seed;
            state          <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (ram_addr == LAST_ADDR) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            state    <= S_READ;
          end else begin
            ram_addr <= ram_addr + 1'b1;
            ram_din  <= ram_din + 1'b1;
          end
        end

        S_READ: begin
          if (ram_addr == LAST_ADDR) begin
            ram_en   <= 1'b0;
            ram_addr <= '0;
            state    <= S_FLUSH;
          end else begin
            ram_addr <= ram_addr + 1'b1;
          end
        end

        S_FLUSH: begin
          // The last read's compare resolves this cycle; fold it into pass.
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_next == '0);
          state <= S_DONE;
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_bist_ctrl
//  Purpose  : Scoreboard bench for ram_bist_ctrl with a behavioural RAM that
//             can inject read faults.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_bist_ctrl;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] seed = '0;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          busy, done, pass;
  logic [AW:0]   err_cnt;
  logic [AW-1:0] first_err_addr;

  ram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // 0: healthy, 1: reads of addr 5 and 20 return 0xAA, 2: every read returns 0x00
  int fault_mode = 0;

  function automatic logic [DW-1:0] ram_fault(input int mode, input int addr, input logic [DW-1:0] v);
    if (mode == 1 && (addr == 5 || addr == 20)) return 8'hAA;
    if (mode == 2) return 8'h00;
    return v;
  endfunction

  // Behavioural 32x8 RAM, registered read
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q = '0;
  logic [AW-1:0] rd_addr_q = '0;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else begin
        rd_q      <= mem[ram_addr];
        rd_addr_q <= ram_addr;
      end
    end
  end
  assign ram_dout = ram_fault(fault_mode, int'(rd_addr_q), rd_q);

  typedef struct { int cyc; int addr; int data; } acc_t;
  typedef struct { int cyc; int err; int first; int pass; } res_t;
  acc_t wq[$];
  acc_t rq[$];
  res_t resq[$];

  task automatic chk(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s", msg);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({ram_en, ram_we, ram_addr, ram_din, busy, done, pass, err_cnt, first_err_addr} == '0,
        $sformatf("%s outputs: en=%b we=%b addr=%0d din=%h busy=%b done=%b pass=%b err=%0d first=%0d, required all 0",
                  tag, ram_en, ram_we, ram_addr, ram_din, busy, done, pass, err_cnt, first_err_addr));
  endtask

  // Reference model: pushes the full expected transaction stream of one run.
  task automatic start_run(input logic [DW-1:0] s, input int mode);
    int sc;
    int err;
    int first;
    logic [DW-1:0] exp_v;
    res_t r;
    fault_mode = mode;
    seed  = s;
    start = 1'b1;
    sc    = cyc;
    err   = 0;
    first = 0;
    for (int k = 0; k < DEPTH; k++) begin
      exp_v = s + DW'(k);
      wq.push_back('{sc + 1 + k, k, int'(exp_v)});
      rq.push_back('{sc + 1 + DEPTH + k, k, 0});
      if (ram_fault(mode, k, exp_v) != exp_v) begin
        if (err == 0) first = k;
        err++;
      end
    end
    if (err > DEPTH) err = DEPTH;
    r = '{sc + 2 * DEPTH + 2, err, first, (err == 0) ? 1 : 0};
    resq.push_back(r);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_start(input logic [DW-1:0] s);
    seed  = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (resq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (resq.size() != 0) begin
      chk(1'b0, $sformatf("done_timeout: pending results=%0d, required 0", resq.size()));
      resq.delete();
    end
    chk(wq.size() == 0 && rq.size() == 0,
        $sformatf("leftover_accesses: writes=%0d reads=%0d, required 0/0", wq.size(), rq.size()));
    wq.delete();
    rq.delete();
  endtask

  // Monitor: compares every RAM access and every done pulse against the queues.
  always @(negedge clk) begin
    acc_t e;
    res_t r;
    if (rst_n) begin
      if (ram_en && ram_we) begin
        if (wq.size() == 0) chk(1'b0, $sformatf("unexpected_write: cyc=%0d addr=%0d, required none", cyc, ram_addr));
        else begin
          e = wq.pop_front();
          chk(cyc == e.cyc && int'(ram_addr) == e.addr && int'(ram_din) == e.data && busy,
              $sformatf("write: cyc=%0d addr=%0d din=%h busy=%b, required cyc=%0d addr=%0d din=%h busy=1",
                        cyc, ram_addr, ram_din, busy, e.cyc, e.addr, e.data[7:0]));
        end
      end
      if (ram_en && !ram_we) begin
        if (rq.size() == 0) chk(1'b0, $sformatf("unexpected_read: cyc=%0d addr=%0d, required none", cyc, ram_addr));
        else begin
          e = rq.pop_front();
          chk(cyc == e.cyc && int'(ram_addr) == e.addr && busy,
              $sformatf("read: cyc=%0d addr=%0d busy=%b, required cyc=%0d addr=%0d busy=1",
                        cyc, ram_addr, busy, e.cyc, e.addr));
        end
      end
      if (done) begin
        if (resq.size() == 0) chk(1'b0, $sformatf("unexpected_done: cyc=%0d, required no done", cyc));
        else begin
          r = resq.pop_front();
          chk(cyc == r.cyc && int'(err_cnt) == r.err && int'(first_err_addr) == r.first &&
              int'(pass) == r.pass && !busy,
              $sformatf("result: cyc=%0d err=%0d first=%0d pass=%b busy=%b, required cyc=%0d err=%0d first=%0d pass=%0d busy=0",
                        cyc, err_cnt, first_err_addr, pass, busy, r.cyc, r.err, r.first, r.pass));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Incrementing pattern from zero
    start_run(8'h00, 0);
    wait_idle();

    // Data wrap across 0xFF -> 0x00
    start_run(8'hF0, 0);
    wait_idle();

    // Injected faults at addr 5 and 20, with ignored starts at cycles 10 and 66
    start_run(8'h10, 1);                 // now in cycle 1
    repeat (9) @(posedge clk); #1;       // cycle 10
    pulse_start(8'h77);                  // now cycle 11
    repeat (55) @(posedge clk); #1;      // cycle 66 (DONE)
    pulse_start(8'h66);                  // now cycle 67
    start_run(8'h3C, 0);                 // accepted at cycle 67; now its cycle 1
    chk(err_cnt == '0 && first_err_addr == '0 && pass == 1'b0 && busy == 1'b1,
        $sformatf("clear_on_start: err=%0d first=%0d pass=%b busy=%b, required 0/0/0/1",
                  err_cnt, first_err_addr, pass, busy));
    wait_idle();

    // Reset while writing addr 10 aborts the run with no done pulse
    start_run(8'($urandom), 0);          // cycle 1
    repeat (10) @(posedge clk); #1;      // cycle 11
    chk(ram_addr == 5'd10 && ram_we == 1'b1,
        $sformatf("pre_abort: addr=%0d we=%b, required 10/1", ram_addr, ram_we));
    rst_n = 1'b0;
    #1;
    wq.delete();
    rq.delete();
    resq.delete();
    chk_reset_outputs("abort");
    repeat (2) @(posedge clk); #1;
    chk_reset_outputs("abort_hold");
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk_reset_outputs("post_abort_idle");
    start_run(8'h01, 0);
    wait_idle();

    // Stuck-at-zero read data: every compare fails
    start_run(8'h01, 2);
    wait_idle();

    // Randomized runs
    for (int i = 0; i < 5; i++) begin
      start_run(8'($urandom), int'($urandom_range(0, 2)));
      wait_idle();
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
      #1;
    end

    // Nothing must happen while idle
    repeat (10) @(posedge clk); #1;
    chk(busy == 1'b0 && ram_en == 1'b0 && done == 1'b0,
        $sformatf("final_idle: busy=%b en=%b done=%b, required 0/0/0", busy, ram_en, done));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
